mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit: one request at a time, RAM signals held for ACCESS_CYCLES
// cycles inside a single SRAM region, big-endian byte lanes, registered result.
module mem_lsu #(
  parameter logic [31:0] BASE_ADDR     = 32'h80000000,
  parameter logic [31:0] REGION_SIZE   = 32'h00400000,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  waddr_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  output logic        valid_o,
  output logic        stallreq,
  output logic        misalign_o,
  output logic        fault_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  // state  | meaning
  // IDLE   | accepting requests; NOP/misaligned/fault answered next cycle
  // ACCESS | RAM signals driven from latched request; cnt counts down to 0

  localparam logic [3:0]  OP_LB  = 4'd1;
  localparam logic [3:0]  OP_LBU = 4'd2;
  localparam logic [3:0]  OP_LH  = 4'd3;
  localparam logic [3:0]  OP_LHU = 4'd4;
  localparam logic [3:0]  OP_LW  = 4'd5;
  localparam logic [3:0]  OP_SB  = 4'd6;
  localparam logic [3:0]  OP_SH  = 4'd7;
  localparam logic [3:0]  OP_SW  = 4'd8;
  localparam logic [3:0]  CNT_INIT   = 4'(ACCESS_CYCLES - 1);
  localparam logic [32:0] REGION_END = {1'b0, BASE_ADDR} + {1'b0, REGION_SIZE};

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic        fault_q, fault_d;

  logic        req_mem, req_half, req_word, req_misalign, req_fault, req_legal;
  logic        lat_byte, lat_half, lat_store;
  logic        acc;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  assign req_mem      = (op_i >= OP_LB) && (op_i <= OP_SW);
  assign req_half     = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
  assign req_word     = (op_i == OP_LW) || (op_i == OP_SW);
  assign req_misalign = (req_half && addr_i[0]) || (req_word && (addr_i[1:0] != 2'b00));
  // 33-bit upper bound so a region touching 2^32 does not wrap to zero
  assign req_fault    = !req_misalign &&
                        ((addr_i < BASE_ADDR) || ({1'b0, addr_i} >= REGION_END));
  assign req_legal    = req_mem && !req_misalign && !req_fault;

  assign lat_byte  = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_SB);
  assign lat_half  = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
  assign lat_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
  assign acc       = (state_q == S_ACCESS);

  always_comb begin
    lane_b = 8'h00;
    case (addr_q[1:0])
      2'b00: lane_b = ram_data_i[31:24];
      2'b01: lane_b = ram_data_i[23:16];
      2'b10: lane_b = ram_data_i[15:8];
      2'b11: lane_b = ram_data_i[7:0];
      default: lane_b = 8'h00;
    endcase
    lane_h = addr_q[1] ? ram_data_i[15:0] : ram_data_i[31:16];
    load_data = ram_data_i;
    case (op_q)
      OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_data = {24'h000000, lane_b};
      OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_data = {16'h0000, lane_h};
      default: load_data = ram_data_i;
    endcase
  end

  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = 32'h0;
    ram_sel_o  = 4'h0;
    ram_data_o = 32'h0;
    if (acc) begin
      ram_ce_o   = 1'b1;
      ram_we_o   = lat_store;
      ram_addr_o = addr_q;
      if (lat_byte) begin
        ram_sel_o  = 4'b1000 >> addr_q[1:0];
        ram_data_o = {4{sdata_q[7:0]}};
      end else if (lat_half) begin
        ram_sel_o  = addr_q[1] ? 4'b0011 : 4'b1100;
        ram_data_o = {2{sdata_q[15:0]}};
      end else begin
        ram_sel_o  = 4'b1111;
        ram_data_o = sdata_q;
      end
      if (!lat_store) ram_data_o = 32'h0;
    end
  end

  assign stallreq = rst && ((!acc && req_valid_i && req_legal) || (acc && (cnt_q != 4'd0)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    wreg_d     = wreg_q;
    waddr_d    = 5'd0;
    we_d       = 1'b0;
    wdata_d    = 32'h0;
    valid_d    = 1'b0;
    misalign_d = 1'b0;
    fault_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (!req_mem) begin
            waddr_d = waddr_i;
            we_d    = we_i;
            wdata_d = wdata_i;
            valid_d = 1'b1;
          end else if (req_misalign) begin
            waddr_d    = waddr_i;
            valid_d    = 1'b1;
            misalign_d = 1'b1;
          end else if (req_fault) begin
            waddr_d = waddr_i;
            valid_d = 1'b1;
            fault_d = 1'b1;
          end else begin
            op_d    = op_i;
            addr_d  = addr_i;
            sdata_d = store_data_i;
            wreg_d  = waddr_i;
            cnt_d   = CNT_INIT;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          waddr_d = wreg_q;
          if (!lat_store) begin
            we_d    = 1'b1;
            wdata_d = load_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op_q       <= 4'd0;
      addr_q     <= 32'h0;
      sdata_q    <= 32'h0;
      wreg_q     <= 5'd0;
      waddr_q    <= 5'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      wreg_q     <= wreg_d;
      waddr_q    <= waddr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
    end
  end

  assign waddr_o    = waddr_q;
  assign we_o       = we_q;
  assign wdata_o    = wdata_q;
  assign valid_o    = valid_q;
  assign misalign_o = misalign_q;
  assign fault_o    = fault_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: transaction-level reference model checked every cycle,
// plus directed transactions with hand-computed results.
module tb_mem_lsu;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam logic [31:0] SIZE = 32'h00400000;
  localparam int          AC   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i, store_data_i, wdata_i, ram_data_i;
  logic [4:0]  waddr_i;
  logic        we_i;
  logic [4:0]  waddr_o;
  logic        we_o, valid_o, stallreq, misalign_o, fault_o;
  logic [31:0] wdata_o, ram_addr_o, ram_data_o;
  logic        ram_ce_o, ram_we_o;
  logic [3:0]  ram_sel_o;

  int checks = 0;
  int errors = 0;

  mem_lsu #(.BASE_ADDR(BASE), .REGION_SIZE(SIZE), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .op_i(op_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i),
    .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o), .valid_o(valid_o),
    .stallreq(stallreq), .misalign_o(misalign_o), .fault_o(fault_o),
    .ram_addr_o(ram_addr_o), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o),
    .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  always #5 clk = ~clk;

  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [3:0] op);
    return (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
  endfunction

  function automatic bit op_signed(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd3);
  endfunction

  function automatic bit is_misaligned(input logic [3:0] op, input logic [31:0] a);
    int n = op_bytes(op);
    if (n == 0) return 1'b0;
    return (a % n) != 0;
  endfunction

  function automatic bit in_region(input logic [31:0] a);
    longint unsigned la = a;
    longint unsigned lb = BASE;
    longint unsigned ls = SIZE;
    return (la >= lb) && (la < lb + ls);
  endfunction

  // lane k is big-endian byte k (bits 31-8k downto 24-8k)
  function automatic logic [3:0] exp_sel(input logic [3:0] op, input logic [31:0] a);
    logic [3:0] s = 4'h0;
    int n = op_bytes(op);
    int st = (n == 4) ? 0 : int'(a % 4);
    for (int k = 0; k < 4; k++)
      if (k >= st && k < st + n) s[3-k] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_store(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] r = 32'h0;
    int n = op_bytes(op);
    for (int k = 0; k < 4; k++)
      r[31-8*k -: 8] = d[8*(n-1-(k % n)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sel = {28'h0, exp_sel(op, a)};
    longint unsigned v = 0;
    int n = op_bytes(op);
    for (int k = 0; k < 4; k++)
      if (sel[3-k]) v = (v << 8) | longint'(rd[31-8*k -: 8]);
    if (op_signed(op) && v[8*n-1]) v = v | (~64'h0 << (8*n));
    return v[31:0];
  endfunction

  // reference model: m_left = ACCESS cycles still to go (0 means idle)
  int          m_left;
  logic [3:0]  m_op;
  logic [31:0] m_addr, m_sdata;
  logic [4:0]  m_wreg;
  logic        e_valid, e_mis, e_fault, e_we;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left = 0; m_op = 0; m_addr = 0; m_sdata = 0; m_wreg = 0;
      e_valid = 0; e_mis = 0; e_fault = 0; e_we = 0; e_waddr = 0; e_wdata = 0;
    end else begin
      e_valid = 0; e_mis = 0; e_fault = 0; e_we = 0; e_waddr = 0; e_wdata = 0;
      if (m_left == 0) begin
        if (req_valid_i) begin
          if (op_bytes(op_i) == 0) begin
            e_valid = 1; e_we = we_i; e_waddr = waddr_i; e_wdata = wdata_i;
          end else if (is_misaligned(op_i, addr_i)) begin
            e_valid = 1; e_mis = 1;
          end else if (!in_region(addr_i)) begin
            e_valid = 1; e_fault = 1;
          end else begin
            m_op = op_i; m_addr = addr_i; m_sdata = store_data_i; m_wreg = waddr_i;
            m_left = AC;
          end
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          e_valid = 1;
          if (!op_store(m_op)) begin
            e_we = 1; e_waddr = m_wreg; e_wdata = exp_load(m_op, m_addr, ram_data_i);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic stall_e;
    forever begin
      @(negedge clk);
      stall_e = rst && ((m_left == 0 && req_valid_i && op_bytes(op_i) != 0 &&
                         !is_misaligned(op_i, addr_i) && in_region(addr_i)) || m_left > 1);
      chk("valid_o", valid_o, e_valid);
      chk("misalign_o", misalign_o, e_mis);
      chk("fault_o", fault_o, e_fault);
      chk("stallreq", stallreq, stall_e);
      chk("ram_ce_o", ram_ce_o, m_left > 0);
      chk("ram_we_o", ram_we_o, m_left > 0 && op_store(m_op));
      chk("ram_addr_o", ram_addr_o, (m_left > 0) ? m_addr : 32'h0);
      chk("ram_sel_o", ram_sel_o, (m_left > 0) ? exp_sel(m_op, m_addr) : 4'h0);
      chk("ram_data_o", ram_data_o,
          (m_left > 0 && op_store(m_op)) ? exp_store(m_op, m_sdata) : 32'h0);
      if (e_valid) begin
        chk("we_o", we_o, e_we);
        if (!e_mis && !e_fault) chk("wdata_o", wdata_o, e_wdata);
        if (e_we) chk("waddr_o", waddr_o, e_waddr);
      end
    end
  endtask

  int          r_stall;
  logic [3:0]  r_sel;
  logic [31:0] r_rdata;
  logic        r_rwe, r_ce, r_we, r_mis, r_fault;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] wa, input logic we, input logic [31:0] wd,
                       input logic [31:0] rd);
    bit got = 0;
    @(posedge clk); #1;
    req_valid_i = 1; op_i = op; addr_i = a; store_data_i = sd;
    waddr_i = wa; we_i = we; wdata_i = wd; ram_data_i = rd;
    r_stall = 0; r_sel = 0; r_rdata = 0; r_rwe = 0; r_ce = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (stallreq) r_stall++;
      if (ram_ce_o) begin r_ce = 1; r_sel = ram_sel_o; r_rdata = ram_data_o; r_rwe = ram_we_o; end
      if (valid_o) begin
        got = 1;
        r_we = we_o; r_mis = misalign_o; r_fault = fault_o; r_waddr = waddr_o; r_wdata = wdata_o;
      end else begin
        @(posedge clk); #1;
        req_valid_i = 0;
      end
    end
    chk("result_arrived", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid_i = 0;
  endtask

  initial begin
    int nvalid;
    rst = 0; req_valid_i = 0; op_i = 0; addr_i = 0; store_data_i = 0;
    waddr_i = 0; we_i = 0; wdata_i = 0; ram_data_i = 0;
    fork compare_loop(); join_none

    // legal request pending while in reset must not stall or touch RAM
    req_valid_i = 1; op_i = 4'd5; addr_i = 32'h80000010;
    repeat (3) @(negedge clk);
    chk("rst_stallreq", stallreq, 0);
    chk("rst_ram_ce", ram_ce_o, 0);
    chk("rst_valid", valid_o, 0);
    @(posedge clk); #1 req_valid_i = 0;
    #1 rst = 1;

    do_op(4'd5, 32'h80000010, 0, 5'd3, 0, 0, 32'hDEADBEEF);
    chk("lw_stall_cycles", r_stall, 2);
    chk("lw_sel", r_sel, 4'b1111);
    chk("lw_we", r_we, 1);
    chk("lw_waddr", r_waddr, 5'd3);
    chk("lw_wdata", r_wdata, 32'hDEADBEEF);

    do_op(4'd1, 32'h80000003, 0, 5'd4, 0, 0, 32'h000000F0);
    chk("lb_sel", r_sel, 4'b0001);
    chk("lb_wdata", r_wdata, 32'hFFFFFFF0);
    do_op(4'd2, 32'h80000003, 0, 5'd4, 0, 0, 32'h000000F0);
    chk("lbu_wdata", r_wdata, 32'h000000F0);

    do_op(4'd7, 32'h80000002, 32'h1234ABCD, 5'd6, 0, 0, 0);
    chk("sh_sel", r_sel, 4'b0011);
    chk("sh_ram_data", r_rdata, 32'hABCDABCD);
    chk("sh_ram_we", r_rwe, 1);
    chk("sh_we", r_we, 0);
    chk("sh_wdata", r_wdata, 0);

    do_op(4'd6, 32'h80000001, 32'h0000005A, 5'd1, 0, 0, 0);
    chk("sb_sel", r_sel, 4'b0100);
    chk("sb_ram_data", r_rdata, 32'h5A5A5A5A);

    do_op(4'd3, 32'h80000000, 0, 5'd9, 0, 0, 32'h80011234);
    chk("lh_sel", r_sel, 4'b1100);
    chk("lh_wdata", r_wdata, 32'hFFFF8001);
    do_op(4'd4, 32'h80000002, 0, 5'd9, 0, 0, 32'h12348765);
    chk("lhu_wdata", r_wdata, 32'h00008765);

    do_op(4'd5, 32'h80000006, 0, 5'd2, 0, 0, 0);
    chk("mis_flag", r_mis, 1);
    chk("mis_we", r_we, 0);
    chk("mis_stall", r_stall, 0);
    chk("mis_no_ce", r_ce, 0);
    do_op(4'd5, 32'h00001000, 0, 5'd2, 0, 0, 0);
    chk("fault_flag", r_fault, 1);
    chk("fault_we", r_we, 0);

    do_op(4'd5, 32'h803FFFFC, 0, 5'd8, 0, 0, 32'h11223344);
    chk("top_word_fault", r_fault, 0);
    chk("top_word_wdata", r_wdata, 32'h11223344);
    do_op(4'd5, 32'h80400000, 0, 5'd8, 0, 0, 0);
    chk("end_fault", r_fault, 1);
    do_op(4'd5, 32'h7FFFFFFC, 0, 5'd8, 0, 0, 0);
    chk("below_fault", r_fault, 1);

    do_op(4'd0, 32'h80000000, 0, 5'd5, 1, 32'd7, 0);
    chk("nop_waddr", r_waddr, 5'd5);
    chk("nop_wdata", r_wdata, 32'd7);
    chk("nop_stall", r_stall, 0);
    do_op(4'd12, 32'h80000001, 0, 5'd11, 1, 32'h55, 0);
    chk("op12_nop_wdata", r_wdata, 32'h55);
    chk("op12_no_ce", r_ce, 0);

    // request held high (then turned into a NOP) during ACCESS must be ignored
    @(posedge clk); #1;
    req_valid_i = 1; op_i = 4'd5; addr_i = 32'h80000020; waddr_i = 5'd7; ram_data_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    op_i = 4'd0; wdata_i = 32'h99; we_i = 1;
    @(posedge clk); #1;
    req_valid_i = 0;
    nvalid = 0;
    repeat (4) begin
      @(negedge clk);
      if (valid_o) begin nvalid++; chk("held_wdata", wdata_o, 32'hCAFEF00D); end
    end
    chk("held_valid_count", nvalid, 1);

    // reset in the middle of a store aborts it
    @(posedge clk); #1;
    req_valid_i = 1; op_i = 4'd8; addr_i = 32'h80000040; store_data_i = 32'h01020304;
    @(posedge clk); #1;
    req_valid_i = 0;
    @(negedge clk);
    chk("sw_ce_before_rst", ram_ce_o, 1);
    #2 rst = 0;
    #1;
    chk("sw_ce_after_rst", ram_ce_o, 0);
    chk("sw_stall_after_rst", stallreq, 0);
    chk("sw_valid_after_rst", valid_o, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1;
    nvalid = 0;
    repeat (4) begin
      @(negedge clk);
      if (valid_o) nvalid++;
    end
    chk("abort_no_valid", nvalid, 0);
    do_op(4'd5, 32'h80000044, 0, 5'd12, 0, 0, 32'h0BADF00D);
    chk("post_rst_lw_stall", r_stall, 2);
    chk("post_rst_lw_wdata", r_wdata, 32'h0BADF00D);
    chk("post_rst_lw_waddr", r_waddr, 5'd12);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
